// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Unsigned shift-add sequential multiplier. Both operands are captured on an
//   accepted start. The block then retires one multiplier bit per clock and
//   produces a 2*WIDTH-bit product after exactly WIDTH clocks.
//
//   The partial product and the ripple adder are written out as AND/XOR/OR
//   gates, so the datapath maps directly onto the gate library.
//
// Ports
//   clk           in   1        rising-edge clock
//   reset         in   1        asynchronous, active-high reset
//   op_start      in   1        start request, sampled only in IDLE or DONE
//   op_clear      in   1        abort/clear, returns to IDLE and zeroes result
//   multiplicand  in   WIDTH    operand A, latched on an accepted op_start
//   multiplier    in   WIDTH    operand B, latched on an accepted op_start
//   result        out  2*WIDTH  product, valid while op_done=1
//   op_done       out  1        high while in DONE
//   busy          out  1        high while in EXEC
//   o_dbg_state   out  2        current FSM state code, for observation only
//
// Handshake
//   A request is accepted on a rising edge when op_start=1 and op_clear=0 in
//   IDLE or DONE. op_start is ignored in EXEC. op_clear takes priority over
//   op_start on the same edge. The level op_done marks when result is valid.
//   result keeps its previous value until the next operation completes.
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] result,
    output logic               op_done,
    output logic               busy,
    output logic [1:0]         o_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_mplr;
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_result;
    logic               r_done;
    logic               r_busy;

    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_pp;
    logic [WIDTH:0]     w_sum;
    logic               w_accept;
    logic               w_last;

    // The start request is honoured only in a resting state, and only when
    // no clear is requested on the same edge.
    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                      op_start && !op_clear;
    assign w_last   = (r_count == LAST_STEP);

    // The partial product is the multiplicand gated by the current LSB of the
    // multiplier. A gate-level ripple-carry adder adds it to the low half of
    // the accumulator.
    always_comb begin : adder
        logic c;
        c     = 1'b0;
        w_pp  = r_mcand & {WIDTH{r_mplr[0]}};
        w_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i] = r_acc[i] ^ w_pp[i] ^ c;
            c        = (r_acc[i] & w_pp[i]) | (c & (r_acc[i] ^ w_pp[i]));
        end
        // After every shift, acc[WIDTH] is always zero. Folding it in here
        // leaves the sum unchanged.
        w_sum[WIDTH] = r_acc[WIDTH] ^ c;
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (op_clear)      w_state_nxt = ST_IDLE;
                else if (op_start) w_state_nxt = ST_EXEC;
                else               w_state_nxt = r_state;
            end
            ST_EXEC: begin
                if (op_clear)    w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
                else             w_state_nxt = ST_EXEC;
            end
            default: w_state_nxt = ST_IDLE;   // code 11 recovers to IDLE
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mplr   <= '0;
            r_mcand  <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // The status flags are registered from the next state, so they
            // change on the same edge as the state itself.
            r_busy  <= (w_state_nxt == ST_EXEC);
            r_done  <= (w_state_nxt == ST_DONE);

            if (op_clear) begin
                r_result <= '0;
            end else if (w_accept) begin
                r_mcand <= multiplicand;
                r_mplr  <= multiplier;
                r_acc   <= '0;
                r_count <= '0;
            end else if (r_state == ST_EXEC) begin
                // {acc, mplr} <= {sum, mplr} >> 1
                r_acc   <= {1'b0, w_sum[WIDTH:1]};
                r_mplr  <= {w_sum[0], r_mplr[WIDTH-1:1]};
                r_count <= r_count + 1'b1;
                if (w_last) begin
                    r_result <= {w_sum, r_mplr[WIDTH-1:1]};
                end
            end
        end
    end

    assign result      = r_result;
    assign op_done     = r_done;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    localparam int WIDTH = 32;

    logic              clk;
    logic              reset;
    logic              op_start;
    logic              op_clear;
    logic [WIDTH-1:0]  multiplicand;
    logic [WIDTH-1:0]  multiplier;
    logic [63:0]       result;
    logic              op_done;
    logic              busy;
    logic [1:0]        o_dbg_state;

    int vectors;
    int miscompares;

    seq_multiplier #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .op_done      (op_done),
        .busy         (busy),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    // The request is presented at a negedge and accepted on the next posedge.
    // The task returns at the negedge that follows the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        op_start     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Counts the negedges until op_done, beginning at start_cnt. The wait is
    // bounded. Every cycle before completion must show busy=1.
    task automatic wait_done(input int start_cnt, input string name, output int cycles);
        int busy_bad;
        busy_bad = 0;
        cycles   = start_cnt;
        while (!op_done && cycles < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            cycles++;
        end
        vectors++;
        if (busy_bad != 0) begin
            miscompares++;
            $display("FAIL %s busy_during_exec: %0d cycles had busy=0, required 0 such cycles", name, busy_bad);
        end
        vectors++;
        if (op_done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: op_done never rose within %0d cycles", name, cycles);
        end
    endtask

    task automatic check_done(input string name, input int cycles, input logic [63:0] exp);
        vectors++;
        if (cycles !== 32) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, required 32", name, cycles);
        end
        vectors++;
        if (result !== exp) begin
            miscompares++;
            $display("FAIL %s result: got %h, required %h", name, result, exp);
        end
        vectors++;
        if (busy !== 1'b0 || o_dbg_state !== 2'b10) begin
            miscompares++;
            $display("FAIL %s done_state: busy=%b state=%b, required busy=0 state=10", name, busy, o_dbg_state);
        end
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        #12;
        vectors++;
        if (result !== 64'h0 || op_done !== 1'b0 || busy !== 1'b0 || o_dbg_state !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: result=%h done=%b busy=%b state=%b, required all 0",
                     result, op_done, busy, o_dbg_state);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        start_op(32'd3, 32'd5);
        wait_done(0, "basic_3x5", cyc);
        check_done("basic_3x5", cyc, 64'h0000_0000_0000_000F);
        repeat (5) @(negedge clk);
        vectors++;
        if (op_done !== 1'b1 || result !== 64'hF) begin
            miscompares++;
            $display("FAIL hold_done: done=%b result=%h, required done=1 result=f", op_done, result);
        end
        clear_pulse();
        vectors++;
        if (result !== 64'h0 || op_done !== 1'b0 || busy !== 1'b0 || o_dbg_state !== 2'b00) begin
            miscompares++;
            $display("FAIL clear_from_done: result=%h done=%b busy=%b state=%b, required 0/0/0/00",
                     result, op_done, busy, o_dbg_state);
        end
    endtask

    task automatic test_carry();
        int cyc;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, "max_operands", cyc);
        check_done("max_operands", cyc, 64'hFFFF_FFFE_0000_0001);
        clear_pulse();
    endtask

    task automatic test_zero();
        int cyc;
        start_op(32'h1234_5678, 32'h0);
        wait_done(0, "zero_operand", cyc);
        check_done("zero_operand", cyc, 64'h0);
        clear_pulse();
    endtask

    task automatic test_ignore_and_clear();
        int cyc;
        start_op(32'd7, 32'd6);
        repeat (9) @(negedge clk);
        op_start     = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        @(negedge clk);
        op_start     = 1'b0;
        wait_done(10, "start_in_exec", cyc);
        check_done("start_in_exec", cyc, 64'd42);

        // Abort a second operation part-way through EXEC.
        start_op(32'd5, 32'd5);
        repeat (14) @(negedge clk);
        vectors++;
        if (result !== 64'd42 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL old_result_in_exec: result=%h busy=%b, required 2a/1", result, busy);
        end
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        vectors++;
        if (result !== 64'h0 || busy !== 1'b0 || op_done !== 1'b0 || o_dbg_state !== 2'b00) begin
            miscompares++;
            $display("FAIL clear_in_exec: result=%h busy=%b done=%b state=%b, required 0/0/0/00",
                     result, busy, op_done, o_dbg_state);
        end

        // Clear and start requested on the same edge: clear takes priority.
        op_clear     = 1'b1;
        op_start     = 1'b1;
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        @(negedge clk);
        op_clear = 1'b0;
        op_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_dbg_state !== 2'b00 || busy !== 1'b0 || op_done !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_beats_start: state=%b busy=%b done=%b, required 00/0/0",
                     o_dbg_state, busy, op_done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(32'd7, 32'd6);
        wait_done(0, "b2b_first", cyc);
        check_done("b2b_first", cyc, 64'd42);
        start_op(32'h0001_0000, 32'h0001_0000);
        vectors++;
        if (result !== 64'd42 || busy !== 1'b1 || op_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: result=%h busy=%b done=%b, required 2a/1/0", result, busy, op_done);
        end
        wait_done(0, "b2b_second", cyc);
        check_done("b2b_second", cyc, 64'h0000_0001_0000_0000);
    endtask

    task automatic test_async_reset();
        start_op(32'd11, 32'd13);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (result !== 64'h0 || op_done !== 1'b0 || busy !== 1'b0 || o_dbg_state !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset: result=%h done=%b busy=%b state=%b, required all 0",
                     result, op_done, busy, o_dbg_state);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (o_dbg_state !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_idle: state=%b busy=%b, required 00/0", o_dbg_state, busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors      = 0;
        miscompares  = 0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_ignore_and_clear();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
